// File: rtl/tx_pkg.sv
// Shared UART transmit definitions: FSM state encoding and the 16x oversampling ratio.
// The rx block imports OVERSAMPLE from here so both ends agree on bit length.
package tx_pkg;
  localparam int         OVERSAMPLE  = 16;
  localparam logic [3:0] SAMPLE_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] BIT_LAST    = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;
endpackage

// File: rtl/tx_fifo.sv
// Synchronous byte FIFO with registered count; writes while full and reads while empty are ignored.
// dout shows the head entry combinationally from storage so the consumer can load it on the pop edge.
module tx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          push_i,
  input  logic [7:0]                    din_i,
  input  logic                          pop_i,
  output logic [7:0]                    dout_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          full_o,
  output logic                          empty_o
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/tx_buffered.sv
// FIFO-buffered 8N1 UART transmitter; each bit spans OVERSAMPLE clken ticks, frames run back-to-back.
// tx is a flop; a byte becomes eligible to start only on the tick after it was written.
module tx_buffered
  import tx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_50m,
  input  logic       rst,
  input  logic       clken,
  input  logic [7:0] din,
  input  logic       wr_en,
  output logic       full,
  output logic       busy,
  output logic       tx
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e     state_q;
  logic [3:0]    sample_q;
  logic [2:0]    bitpos_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          last_sample;
  logic          pop;

  assign last_sample = (sample_q == SAMPLE_LAST);
  // Empty flag is registered, so a byte pushed this cycle cannot be popped until a later tick.
  assign pop = clken && !fifo_empty &&
               ((state_q == ST_IDLE) || ((state_q == ST_STOP) && last_sample));

  tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_50m),
    .rst_i   (rst),
    .push_i  (wr_en),
    .din_i   (din),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .full_o  (full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sample_q <= '0;
      bitpos_q <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
    end else if (clken) begin
      case (state_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q  <= fifo_dout;
            sample_q <= '0;
            tx_q     <= 1'b0;
            state_q  <= ST_START;
          end
        end
        ST_START: begin
          sample_q <= sample_q + 4'd1;
          if (last_sample) begin
            bitpos_q <= '0;
            tx_q     <= shift_q[0];
            state_q  <= ST_DATA;
          end
        end
        ST_DATA: begin
          sample_q <= sample_q + 4'd1;
          if (last_sample) begin
            if (bitpos_q == BIT_LAST) begin
              tx_q    <= 1'b1;
              state_q <= ST_STOP;
            end else begin
              bitpos_q <= bitpos_q + 3'd1;
              shift_q  <= {1'b0, shift_q[7:1]};
              tx_q     <= shift_q[1];
            end
          end
        end
        ST_STOP: begin
          sample_q <= sample_q + 4'd1;
          if (last_sample) begin
            if (pop) begin
              shift_q <= fifo_dout;
              tx_q    <= 1'b0;
              state_q <= ST_START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          sample_q <= '0;
          tx_q     <= 1'b1;
        end
      endcase
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != ST_IDLE) || (fifo_count != '0);
endmodule
